wb_excp_stage: RTL and testbench
================================

WB_EXCP_STAGE -- requirements
Module: wb_excp_stage

Interface
REQ-001 SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, synchronous, active-high); clock `clk`.
REQ-002 SHALL have `ms_to_ws_valid` (in, 1, MEM has an instruction) and `ws_allowin` (out, 1, WB can accept).
REQ-003 SHALL have `ms_pc` (in, 32), `ms_badv` (in, 32, faulting data address) and `ms_ertn` (in, 1).
REQ-004 SHALL have `ms_ex_vec` (in, 6, exception flags): [0] INT, [1] ADEF, [2] INE, [3] SYS, [4] BRK, [5] ALE.
REQ-005 SHALL have `ms_csr_we` (in, 1), `ms_csr_num` (in, 14), `ms_csr_wmask` (in, 32) and `ms_csr_wdata` (in, 32).
REQ-006 SHALL have `ms_rf_we` (in, 1), `ms_rf_waddr` (in, 5) and `ms_rf_wdata` (in, 32).
REQ-007 SHALL have `wb_ex` (out, 1), `wb_ecode` (out, 6), `wb_esubcode` (out, 9), `wb_pc` (out, 32), `wb_badv` (out, 32) and `ertn_flush` (out, 1), all to the CSR file.
REQ-008 SHALL have `csr_we` (out, 1), `csr_wnum` (out, 14), `csr_wmask` (out, 32) and `csr_wdata` (out, 32).
REQ-009 SHALL have `rf_we` (out, 1), `rf_waddr` (out, 5) and `rf_wdata` (out, 32).
REQ-010 SHALL have `ws_flush` (out, 1, kill IF/ID/EX/MEM) and `ws_valid_o` (out, 1).

Function
REQ-011 SHALL hold one instruction in a WB register set (`ws_valid` plus captured inputs); it loads when `ms_to_ws_valid && ws_allowin`.
REQ-012 SHALL drive `ws_allowin` = 1 except in the cycle after a flush cycle (the FLUSH_HOLD state), when it SHALL be 0.
REQ-013 SHALL implement a 2-state FSM:
- RUN -> FLUSH_HOLD when `ws_flush` = 1.
- FLUSH_HOLD -> RUN unconditionally after 1 cycle.
REQ-014 SHALL clear `ws_valid` on the next edge when `ws_flush` = 1, even if `ms_to_ws_valid` = 1 (the incoming instruction is dropped).
REQ-015 SHALL assert `wb_ex` = `ws_valid` && (`ms_ex_vec` captured != 0), combinationally from the WB registers (0-cycle latency to the CSR file).
REQ-016 SHALL select the exception by fixed priority INT > ADEF > INE > SYS > BRK > ALE, with these codes:

| Exception | `wb_ecode` | `wb_esubcode` |
|---|---|---|
| INT | 0x00 | 0 |
| ADEF | 0x08 | 0 |
| INE | 0x0D | 0 |
| SYS | 0x0B | 0 |
| BRK | 0x0C | 0 |
| ALE | 0x09 | 0 |

REQ-017 SHALL drive `wb_badv` = captured PC for ADEF and captured `ms_badv` otherwise; `wb_pc` SHALL always be the captured PC.
REQ-018 SHALL assert `ertn_flush` = `ws_valid` && ertn && !`wb_ex`; when an exception and ERTN coincide, the exception wins.
REQ-019 SHALL drive `ws_flush` = `wb_ex` | `ertn_flush`.
REQ-020 SHALL suppress `csr_we` and `rf_we` when `wb_ex` = 1 or `ws_valid` = 0; otherwise they equal the captured enables.
REQ-021 SHALL drive `wb_ecode`, `wb_esubcode` and `wb_badv` as 0 when `wb_ex` = 0.

Reset
REQ-022 SHALL, on reset, set `ws_valid` = 0, the FSM to RUN, and all captured fields to 0.
REQ-023 SHALL, after reset, present all outputs as 0 except `ws_allowin` = 1.
REQ-024 SHALL, on reset asserted mid-flush, return to RUN and drop the held instruction without committing it.

Configuration
REQ-025 SHALL, with `WB_TRACE_EN` defined, add outputs `debug_wb_pc` (32), `debug_wb_rf_we` (4), `debug_wb_rf_wnum` (5) and `debug_wb_rf_wdata` (32).
- `debug_wb_rf_we` = {4{`rf_we`}}.
- The other trace outputs mirror `wb_pc`, `rf_waddr` and `rf_wdata`.
REQ-026 SHALL, with `WB_TRACE_EN` defined, also add `retire_cnt` (out, 32).
- Reset to 0.
- Increments by 1 per cycle in which `ws_valid` && !`wb_ex`.
- Wraps from 0xFFFFFFFF to 0.
REQ-027 SHALL, without `WB_TRACE_EN`, have neither these ports nor the counter logic.

Verification
REQ-028 SHALL cover normal commit: `ms_to_ws_valid`=1, ex_vec=0, rf_we=1, waddr=5, wdata=0x1234 -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234, `ws_flush`=0.
REQ-029 SHALL cover SYS: ex_vec=6'b001000, pc=0x1C000100 -> `wb_ex`=1, `wb_ecode`=0x0B, `wb_pc`=0x1C000100, `rf_we`=0, `csr_we`=0, `ws_flush`=1; next cycle `ws_allowin`=0 and `ws_valid_o`=0.
REQ-030 SHALL cover priority: ex_vec=6'b100011 -> `wb_ecode`=0x00 (INT); ex_vec=6'b100010, pc=0x8 -> `wb_ecode`=0x08, `wb_badv`=0x8.
REQ-031 SHALL cover ALE: ex_vec=6'b100000, badv=0x1003 -> `wb_ecode`=0x09, `wb_badv`=0x1003.
REQ-032 SHALL cover ERTN: ertn=1, ex_vec=0 -> `ertn_flush`=1, `wb_ex`=0; ertn=1 with SYS -> `ertn_flush`=0, `wb_ex`=1.
REQ-033 SHALL cover reset during FLUSH_HOLD: reset=1 for one cycle -> `ws_allowin`=1, `ws_valid_o`=0, `retire_cnt`=0 (with `WB_TRACE_EN` defined).

Source files
------------

// File: rtl/wb_excp_stage.sv
// Writeback stage with precise exception/ERTN resolution and pipeline flush.
// Optional trace ports and retire counter are built when WB_TRACE_EN is defined.
module wb_excp_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_badv,
    input  logic        ms_ertn,
    input  logic [5:0]  ms_ex_vec,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wdata,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_rf_waddr,
    input  logic [31:0] ms_rf_wdata,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_badv,
    output logic        ertn_flush,
    output logic        csr_we,
    output logic [13:0] csr_wnum,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
`ifdef WB_TRACE_EN
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] retire_cnt,
`endif
    output logic        ws_flush,
    output logic        ws_valid_o
);

    typedef enum logic [0:0] {StRun, StFlushHold} state_e;

    state_e      state_q, state_d;
    logic        ws_valid_q, ws_valid_d;
    logic        load;
    logic [31:0] pc_q, badv_q;
    logic        ertn_q;
    logic [5:0]  ex_vec_q;
    logic        csr_we_q;
    logic [13:0] csr_num_q;
    logic [31:0] csr_wmask_q, csr_wdata_q;
    logic        rf_we_q;
    logic [4:0]  rf_waddr_q;
    logic [31:0] rf_wdata_q;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StRun;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:       if (ws_flush) state_d = StFlushHold;
            StFlushHold: state_d = StRun;
            default:     state_d = StRun;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ws_allowin = (state_q == StRun);
    end

    // A flushing cycle drops whatever MEM is offering.
    assign load = ms_to_ws_valid && ws_allowin && !ws_flush;

    always_comb begin
        ws_valid_d = ws_valid_q;
        if (ws_flush)        ws_valid_d = 1'b0;
        else if (ws_allowin) ws_valid_d = ms_to_ws_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid_q  <= 1'b0;
            pc_q        <= '0;
            badv_q      <= '0;
            ertn_q      <= 1'b0;
            ex_vec_q    <= '0;
            csr_we_q    <= 1'b0;
            csr_num_q   <= '0;
            csr_wmask_q <= '0;
            csr_wdata_q <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            ws_valid_q <= ws_valid_d;
            if (load) begin
                pc_q        <= ms_pc;
                badv_q      <= ms_badv;
                ertn_q      <= ms_ertn;
                ex_vec_q    <= ms_ex_vec;
                csr_we_q    <= ms_csr_we;
                csr_num_q   <= ms_csr_num;
                csr_wmask_q <= ms_csr_wmask;
                csr_wdata_q <= ms_csr_wdata;
                rf_we_q     <= ms_rf_we;
                rf_waddr_q  <= ms_rf_waddr;
                rf_wdata_q  <= ms_rf_wdata;
            end
        end
    end

    assign wb_ex      = ws_valid_q && (ex_vec_q != 6'd0);
    assign ertn_flush = ws_valid_q && ertn_q && !wb_ex;
    assign ws_flush   = wb_ex | ertn_flush;
    assign ws_valid_o = ws_valid_q;
    assign wb_pc      = pc_q;

    // Fixed priority: INT > ADEF > INE > SYS > BRK > ALE
    always_comb begin
        wb_ecode    = 6'h00;
        wb_esubcode = 9'd0;
        wb_badv     = 32'd0;
        if (wb_ex) begin
            wb_badv = badv_q;
            if (ex_vec_q[0]) begin
                wb_ecode = 6'h00;
            end else if (ex_vec_q[1]) begin
                wb_ecode = 6'h08;
                wb_badv  = pc_q;
            end else if (ex_vec_q[2]) begin
                wb_ecode = 6'h0D;
            end else if (ex_vec_q[3]) begin
                wb_ecode = 6'h0B;
            end else if (ex_vec_q[4]) begin
                wb_ecode = 6'h0C;
            end else begin
                wb_ecode = 6'h09;
            end
        end
    end

    assign csr_we    = csr_we_q && ws_valid_q && !wb_ex;
    assign csr_wnum  = csr_num_q;
    assign csr_wmask = csr_wmask_q;
    assign csr_wdata = csr_wdata_q;
    assign rf_we     = rf_we_q && ws_valid_q && !wb_ex;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

`ifdef WB_TRACE_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (ws_valid_q && !wb_ex) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retire_cnt_q <= '0;
        else       retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt        = retire_cnt_q;
    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_excp_stage.sv
// Scoreboard bench for wb_excp_stage: directed vectors push expected results,
// a negedge monitor pops and compares whenever WB holds a valid instruction.
module tb_wb_excp_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_badv;
    logic        ms_ertn;
    logic [5:0]  ms_ex_vec;
    logic        ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask, ms_csr_wdata;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_badv;
    logic        ertn_flush;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask, csr_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_flush, ws_valid_o;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata, retire_cnt;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    always #5 clk = ~clk;

    wb_excp_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ms_to_ws_valid (ms_to_ws_valid),
        .ws_allowin     (ws_allowin),
        .ms_pc          (ms_pc),
        .ms_badv        (ms_badv),
        .ms_ertn        (ms_ertn),
        .ms_ex_vec      (ms_ex_vec),
        .ms_csr_we      (ms_csr_we),
        .ms_csr_num     (ms_csr_num),
        .ms_csr_wmask   (ms_csr_wmask),
        .ms_csr_wdata   (ms_csr_wdata),
        .ms_rf_we       (ms_rf_we),
        .ms_rf_waddr    (ms_rf_waddr),
        .ms_rf_wdata    (ms_rf_wdata),
        .wb_ex          (wb_ex),
        .wb_ecode       (wb_ecode),
        .wb_esubcode    (wb_esubcode),
        .wb_pc          (wb_pc),
        .wb_badv        (wb_badv),
        .ertn_flush     (ertn_flush),
        .csr_we         (csr_we),
        .csr_wnum       (csr_wnum),
        .csr_wmask      (csr_wmask),
        .csr_wdata      (csr_wdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
`ifdef WB_TRACE_EN
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
        .retire_cnt        (retire_cnt),
`endif
        .ws_flush       (ws_flush),
        .ws_valid_o     (ws_valid_o)
    );

    typedef struct {
        logic [5:0]  ex_vec;
        logic [31:0] pc;
        logic [31:0] badv;
        logic        ertn;
        logic        rf_we;
        logic        csr_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        exp_ex;
        logic [5:0]  exp_ecode;
        logic [31:0] exp_badv;
        logic        exp_ertn;
        logic        exp_flush;
        logic        exp_rf_we;
        logic        exp_csr_we;
    } vec_t;

    vec_t vecs[12];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each instruction presented by WB against the scoreboard head.
    always @(negedge clk) begin
        if (ws_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got ws_valid_o=1 expected 0 (pc 0x%08h)", wb_pc);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("wb_pc",       wb_pc,       e.pc);
                chk("wb_ex",       {31'd0, wb_ex},      {31'd0, e.exp_ex});
                chk("wb_ecode",    {26'd0, wb_ecode},   {26'd0, e.exp_ecode});
                chk("wb_esubcode", {23'd0, wb_esubcode}, 32'd0);
                chk("wb_badv",     wb_badv,     e.exp_badv);
                chk("ertn_flush",  {31'd0, ertn_flush}, {31'd0, e.exp_ertn});
                chk("ws_flush",    {31'd0, ws_flush},   {31'd0, e.exp_flush});
                chk("rf_we",       {31'd0, rf_we},      {31'd0, e.exp_rf_we});
                chk("rf_waddr",    {27'd0, rf_waddr},   {27'd0, e.waddr});
                chk("rf_wdata",    rf_wdata,    e.wdata);
                chk("csr_we",      {31'd0, csr_we},     {31'd0, e.exp_csr_we});
                chk("csr_wnum",    {18'd0, csr_wnum},   32'h0000_0006);
                chk("csr_wmask",   csr_wmask,   32'hFFFF_0000);
                chk("csr_wdata",   csr_wdata,   e.pc ^ 32'hA5A5_A5A5);
            end
        end
    end

    // Drive one instruction for one cycle; returns 1ns after it was captured.
    task automatic issue(input vec_t v, input bit expect_out);
        ms_to_ws_valid = 1'b1;
        ms_ex_vec      = v.ex_vec;
        ms_pc          = v.pc;
        ms_badv        = v.badv;
        ms_ertn        = v.ertn;
        ms_rf_we       = v.rf_we;
        ms_rf_waddr    = v.waddr;
        ms_rf_wdata    = v.wdata;
        ms_csr_we      = v.csr_we;
        ms_csr_num     = 14'h006;
        ms_csr_wmask   = 32'hFFFF_0000;
        ms_csr_wdata   = v.pc ^ 32'hA5A5_A5A5;
        if (expect_out) exp_q.push_back(v);
        @(posedge clk); #1;
        ms_to_ws_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        //         ex_vec     pc            badv          ertn rf csr waddr wdata
        //         exp_ex ecode  exp_badv      ertn flush rf csr
        vecs[0]  = '{6'b000000, 32'h1C000000, 32'h0000DEAD, 0, 1, 1, 5'd5, 32'h1234,
                     0, 6'h00, 32'h0, 0, 0, 1, 1};
        vecs[1]  = '{6'b000000, 32'h1C000004, 32'h00000000, 0, 1, 0, 5'd7, 32'hCAFE,
                     0, 6'h00, 32'h0, 0, 0, 1, 0};
        vecs[2]  = '{6'b001000, 32'h1C000100, 32'h00000055, 0, 1, 1, 5'd3, 32'h99,
                     1, 6'h0B, 32'h55, 0, 1, 0, 0};
        vecs[3]  = '{6'b100011, 32'h1C000200, 32'h00000077, 0, 1, 0, 5'd4, 32'h1,
                     1, 6'h00, 32'h77, 0, 1, 0, 0};
        vecs[4]  = '{6'b100010, 32'h00000008, 32'h00000044, 0, 0, 1, 5'd6, 32'h2,
                     1, 6'h08, 32'h8, 0, 1, 0, 0};
        vecs[5]  = '{6'b100000, 32'h1C000300, 32'h00001003, 0, 1, 1, 5'd8, 32'h3,
                     1, 6'h09, 32'h1003, 0, 1, 0, 0};
        vecs[6]  = '{6'b000100, 32'h1C000400, 32'h00000010, 0, 1, 0, 5'd9, 32'h4,
                     1, 6'h0D, 32'h10, 0, 1, 0, 0};
        vecs[7]  = '{6'b010000, 32'h1C000500, 32'h00000020, 0, 1, 0, 5'd10, 32'h5,
                     1, 6'h0C, 32'h20, 0, 1, 0, 0};
        vecs[8]  = '{6'b000000, 32'h1C000600, 32'h00000000, 1, 0, 1, 5'd0, 32'h0,
                     0, 6'h00, 32'h0, 1, 1, 0, 1};
        vecs[9]  = '{6'b001000, 32'h1C000700, 32'h00000030, 1, 1, 1, 5'd11, 32'h6,
                     1, 6'h0B, 32'h30, 0, 1, 0, 0};
        vecs[10] = '{6'b001000, 32'h1C000800, 32'h00000000, 0, 0, 0, 5'd12, 32'h7,
                     1, 6'h0B, 32'h0, 0, 1, 0, 0};
        vecs[11] = '{6'b001000, 32'h1C000900, 32'h00000000, 0, 0, 0, 5'd13, 32'h8,
                     1, 6'h0B, 32'h0, 0, 1, 0, 0};

        reset = 1'b1;
        ms_to_ws_valid = 1'b0;
        ms_ex_vec = '0; ms_pc = '0; ms_badv = '0; ms_ertn = 1'b0;
        ms_rf_we = 1'b0; ms_rf_waddr = '0; ms_rf_wdata = '0;
        ms_csr_we = 1'b0; ms_csr_num = '0; ms_csr_wmask = '0; ms_csr_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_ws_allowin", {31'd0, ws_allowin}, 32'd1);
        chk("rst_ws_valid",   {31'd0, ws_valid_o}, 32'd0);
        chk("rst_wb_ex",      {31'd0, wb_ex},      32'd0);
        chk("rst_ws_flush",   {31'd0, ws_flush},   32'd0);
        chk("rst_ertn_flush", {31'd0, ertn_flush}, 32'd0);
        chk("rst_rf_we",      {31'd0, rf_we},      32'd0);
        chk("rst_csr_we",     {31'd0, csr_we},     32'd0);
        chk("rst_wb_pc",      wb_pc,    32'd0);
        chk("rst_wb_badv",    wb_badv,  32'd0);
        chk("rst_rf_wdata",   rf_wdata, 32'd0);
`ifdef WB_TRACE_EN
        chk("rst_retire_cnt", retire_cnt, 32'd0);
`endif

        // Back-to-back normal commits.
        issue(vecs[0], 1'b1);
        issue(vecs[1], 1'b1);
        step();
`ifdef WB_TRACE_EN
        chk("retire_cnt_two", retire_cnt, 32'd2);
`endif

        // Exceptions and ERTN: each one flushes, then WB refuses input for a cycle.
        for (int i = 2; i <= 9; i++) begin
            issue(vecs[i], 1'b1);
            step();
            chk("hold_ws_allowin", {31'd0, ws_allowin}, 32'd0);
            chk("hold_ws_valid",   {31'd0, ws_valid_o}, 32'd0);
            step();
            chk("run_ws_allowin",  {31'd0, ws_allowin}, 32'd1);
        end

        // Instruction offered during the flush cycle must be dropped.
        issue(vecs[10], 1'b1);
        issue(vecs[1], 1'b0);
        chk("drop_ws_valid", {31'd0, ws_valid_o}, 32'd0);
        step();
        step();

        // Reset while in the flush-hold cycle.
        issue(vecs[11], 1'b1);
        step();
        chk("pre_rst_allowin", {31'd0, ws_allowin}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_ws_allowin", {31'd0, ws_allowin}, 32'd1);
        chk("midrst_ws_valid",   {31'd0, ws_valid_o}, 32'd0);
        chk("midrst_ws_flush",   {31'd0, ws_flush},   32'd0);
`ifdef WB_TRACE_EN
        chk("midrst_retire_cnt", retire_cnt, 32'd0);
`endif
        step();
        step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
